// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if: CPU, VGA and RAM port signals of the frame-buffer arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_valid;
    logic [DATA_W-1:0] vga_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
        output cpu_ack, cpu_rdata, cpu_stall, vga_valid, vga_rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
        input  cpu_ack, cpu_rdata, cpu_stall, vga_valid, vga_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one registered single-port RAM between the CPU memory stage and VGA scan-out.
// VGA wins by default; a bounded-wait counter forces a CPU grant after MAX_WAIT losses.
module vga_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    vga_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_e;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    owner_e            owner_q, owner_d;
    logic              cpu_busy_q, cpu_busy_d;
    logic              vga_busy_q, vga_busy_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              cpu_ok, vga_ok, cpu_gnt, vga_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            cpu_busy_q  <= 1'b0;
            vga_busy_q  <= 1'b0;
            wait_cnt_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            cpu_busy_q  <= cpu_busy_d;
            vga_busy_q  <= vga_busy_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
        end
    end

    // Grants are masked by reset so the RAM port and stall show reset values immediately.
    always_comb begin
        cpu_ok      = bus.cpu_req & ~cpu_busy_q;
        vga_ok      = bus.vga_req & ~vga_busy_q;
        cpu_gnt     = ~reset & cpu_ok & ((wait_cnt_q == WAIT_MAX) | ~vga_ok);
        vga_gnt     = ~reset & vga_ok & ~cpu_gnt;
        owner_d     = cpu_gnt ? OWN_CPU : vga_gnt ? OWN_VGA : OWN_NONE;
        cpu_busy_d  = cpu_gnt;
        vga_busy_d  = vga_gnt;
        wait_cnt_d  = (~bus.cpu_req | cpu_gnt) ? 4'd0 :
                      (cpu_ok & (wait_cnt_q != WAIT_MAX)) ? wait_cnt_q + 4'd1 : wait_cnt_q;
        addr_d      = cpu_gnt ? bus.cpu_addr : vga_gnt ? bus.vga_addr : addr_q;
        wdata_d     = cpu_gnt ? bus.cpu_wdata : wdata_q;
        cpu_rdata_d = (owner_q == OWN_CPU) ? bus.mem_rdata : cpu_rdata_q;
        vga_rdata_d = (owner_q == OWN_VGA) ? bus.mem_rdata : vga_rdata_q;
    end

    always_comb begin
        bus.mem_addr  = addr_d;
        bus.mem_wdata = wdata_d;
        bus.mem_we    = cpu_gnt & bus.cpu_we;
        bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
        bus.cpu_ack   = owner_q == OWN_CPU;
        bus.vga_valid = owner_q == OWN_VGA;
        bus.cpu_rdata = cpu_rdata_d;
        bus.vga_rdata = vga_rdata_d;
    end
endmodule
